ovrd_drive_gain: RTL and testbench



---
 rtl/ovrd_drive_gain.sv | 89 ++++++++
 tb/tb_ovrd_drive_gain.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ovrd_drive_gain.sv
// Drive (pre-gain) stage ahead of the overdrive clamp: slews the applied gain
// toward a non-negative target, multiplies each sample by it and saturates.
module ovrd_drive_gain #(
  parameter int bits_per_level = 12,
  parameter int fxp_size       = 32,
  parameter int ramp_step      = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic signed [fxp_size-1:0] i_sample,
  input  logic signed [fxp_size-1:0] i_gain,
  output logic                       o_valid,
  output logic signed [fxp_size-1:0] o_sample,
  output logic                       o_gain_settled
);

  localparam int W = fxp_size;
  localparam logic signed [W-1:0]   FXP_ONE = W'(1) << bits_per_level;
  localparam logic signed [W:0]     STEP_X  = (W+1)'(ramp_step);
  localparam logic signed [W-1:0]   STEP    = W'(ramp_step);
  localparam logic signed [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [W-1:0]   tgt;
  logic signed [W-1:0]   gain_reg, gain_next;
  logic signed [W:0]     gain_diff;
  logic signed [W-1:0]   s1_reg, g1_reg;
  logic                  v1_reg;
  logic signed [2*W-1:0] q;
  logic signed [W-1:0]   sat;

  assign tgt = i_gain[W-1] ? '0 : i_gain;

  // Difference taken one bit wider so large targets cannot wrap the compare.
  always_comb begin
    gain_diff = {tgt[W-1], tgt} - {gain_reg[W-1], gain_reg};
    gain_next = gain_reg;
    if (i_valid) begin
      if (gain_diff > STEP_X)
        gain_next = gain_reg + STEP;
      else if (gain_diff < -STEP_X)
        gain_next = gain_reg - STEP;
      else
        gain_next = tgt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gain_reg <= FXP_ONE;
      s1_reg   <= '0;
      g1_reg   <= '0;
      v1_reg   <= 1'b0;
    end else begin
      gain_reg <= gain_next;
      v1_reg   <= i_valid;
      if (i_valid) begin
        s1_reg <= i_sample;
        g1_reg <= gain_next;
      end
    end
  end

  // Full-width product, arithmetic shift floors toward -inf.
  always_comb begin
    q = (s1_reg * g1_reg) >>> bits_per_level;
    if (q > SAT_MAX)
      sat = SAT_MAX[W-1:0];
    else if (q < SAT_MIN)
      sat = SAT_MIN[W-1:0];
    else
      sat = q[W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_sample <= '0;
    end else begin
      o_valid <= v1_reg;
      if (v1_reg)
        o_sample <= sat;
    end
  end

  assign o_gain_settled = (gain_reg == tgt);

endmodule

// File: tb/tb_ovrd_drive_gain.sv
// Directed bench for ovrd_drive_gain: reset, ramping, saturation, negative
// targets, valid gaps with redirect, and asynchronous reset mid-stream.
module tb_ovrd_drive_gain;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_valid;
  logic signed [31:0] i_sample;
  logic signed [31:0] i_gain;
  logic               o_valid;
  logic signed [31:0] o_sample;
  logic               o_gain_settled;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ovrd_drive_gain dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (i_valid),
    .i_sample       (i_sample),
    .i_gain         (i_gain),
    .o_valid        (o_valid),
    .o_sample       (o_sample),
    .o_gain_settled (o_gain_settled)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end else begin
      $display("ok   %s: %0d", tag, $signed(got));
    end
  endtask

  // Drive one cycle of inputs, step past the rising edge, land on the falling edge.
  task automatic cyc(input logic v, input logic signed [31:0] s, input logic signed [31:0] gn);
    i_valid  = v;
    i_sample = s;
    i_gain   = gn;
    @(posedge clk);
    @(negedge clk);
  endtask

  int exp_v;

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_sample = 0; i_gain = 4096;

    // Reset and unity gain
    cyc(0, 0, 4096);
    cyc(0, 0, 4096);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_sample", o_sample, 32'd0);
    check("rst_settled", 32'(o_gain_settled), 32'd1);
    rst_n = 1'b1;
    cyc(1, 1000, 4096);
    check("unity_lat1_valid", 32'(o_valid), 32'd0);
    cyc(0, 0, 4096);
    check("unity_valid", 32'(o_valid), 32'd1);
    check("unity_sample", o_sample, 32'd1000);
    check("unity_settled", 32'(o_gain_settled), 32'd1);

    // Ramp up 4096 -> 8192 with constant sample 4096 (output equals gain)
    for (int k = 1; k <= 64; k++) begin
      cyc(1, 4096, 8192);
      if (k >= 2) begin
        check("ramp_valid", 32'(o_valid), 32'd1);
        check("ramp_sample", o_sample, 32'(4096 + 64 * (k - 1)));
      end
      check("ramp_settled", 32'(o_gain_settled), (k == 64) ? 32'd1 : 32'd0);
    end
    cyc(1, 4096, 8192);
    check("ramp_top", o_sample, 32'd8192);

    // Saturation at gain 2.0
    cyc(1, 32'h7FFFFFFF, 8192);
    check("ramp_hold", o_sample, 32'd8192);
    cyc(1, 32'h80000000, 8192);
    check("sat_pos", o_sample, 32'h7FFFFFFF);
    cyc(0, 0, 8192);
    check("sat_neg", o_sample, 32'h80000000);

    // Short reset between edges to restart gain at unity
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;

    // Negative target: descend to 0 and stop; sample 32 is -1 at gain 2048
    for (int k = 1; k <= 66; k++) begin
      cyc(1, (k == 32) ? -32'sd1 : 32'sd4096, -4096);
      if (k >= 2) begin
        exp_v = (k - 1 == 32) ? -1 : ((4096 - 64 * (k - 1)) > 0 ? 4096 - 64 * (k - 1) : 0);
        check("desc_sample", o_sample, 32'(exp_v));
      end
    end
    check("desc_settled", 32'(o_gain_settled), 32'd1);
    cyc(1, 4096, 30);
    check("desc_floor", o_sample, 32'd0);
    check("small_settled", 32'(o_gain_settled), 32'd1);
    cyc(0, 4096, 30);
    check("small_sample", o_sample, 32'd30);

    // Valid gaps: ramp from 30 toward 8192, pause, then redirect down to 256
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 4096, 8192);
      if (k >= 2) check("gap_ramp", o_sample, 32'(30 + 64 * (k - 1)));
    end
    for (int j = 1; j <= 10; j++) begin
      cyc(0, 4096, j * 1000);
      check("gap_valid", 32'(o_valid), (j == 1) ? 32'd1 : 32'd0);
      check("gap_sample", o_sample, 32'd670);
    end
    check("gap_settled", 32'(o_gain_settled), 32'd0);
    for (int m = 1; m <= 3; m++) begin
      cyc(1, 4096, 256);
      if (m >= 2) check("redir_sample", o_sample, 32'(670 - 64 * (m - 1)));
    end
    cyc(0, 4096, 256);
    check("redir_last", o_sample, 32'd478);

    // Asynchronous reset pulse mid-stream
    cyc(1, 4096, 8192);
    cyc(1, 4096, 8192);
    cyc(1, 4096, 8192);
    check("mid_pre", o_sample, 32'd606);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_sample", o_sample, 32'd0);
    check("mid_rst_settled", 32'(o_gain_settled), 32'd0);
    #1 rst_n = 1'b1;
    cyc(1, 4096, 8192);
    check("mid_no_stale", 32'(o_valid), 32'd0);
    cyc(0, 0, 8192);
    check("mid_restart_valid", 32'(o_valid), 32'd1);
    check("mid_restart_sample", o_sample, 32'd4160);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
